// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default payload width and
// the occupancy state encoding (bit 0 = main valid, bit 1 = skid valid).
package pipe_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit payload register with load enable and synchronous clear to RESET_VAL.
// Clear wins over load; value holds when neither is asserted.
module pipe_data_reg #(
  parameter int               WIDTH     = pipe_pkg::WORD_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 1-cycle latency, flush and a
// one-entry skid buffer; in_ready is a flop bit, so out_ready never reaches it combinationally.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  pipe_state_e      state, state_nxt;
  logic             in_fire, out_fire;
  logic             main_load, skid_load, main_from_skid, clear;
  logic [WIDTH-1:0] main_d, skid_q;

  // State bits are the valid flags themselves.
  assign in_ready  = ~state[1];
  assign out_valid = state[0];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign clear     = reset | flush;

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (in_fire) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (in_fire && !out_fire)      state_nxt = ST_FULL;
        else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (out_fire) state_nxt = ST_BUSY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      ST_EMPTY: main_load = in_fire;
      ST_BUSY: begin
        main_load = in_fire & out_fire;
        skid_load = in_fire & ~out_fire;
      end
      ST_FULL: begin
        main_load      = out_fire;
        main_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk   (clk),
    .clear (clear),
    .load  (main_load),
    .d     (main_d),
    .q     (out_data)
  );

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk   (clk),
    .clear (clear),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule
